// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
//   Shared encodings for the load/store unit.
//   - lsu_size_e  : access size carried by req_size
//                   (byte, half, word, reserved)
//   - lsu_state_e : control FSM states of load_store_unit
// -----------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_RSV = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } lsu_state_e;

endpackage : lsu_pkg

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
//   Purely combinational little-endian lane handling for the load/store unit.
//   Ports:
//     rd_word     in  32  word read from memory (load source)
//     old_word    in  32  previously captured memory word (store merge base)
//     wdata       in  32  store data; low byte/half used for sub-word stores
//     addr_lo     in  2   byte offset within the word
//     size        in  2   access size (lsu_size_e)
//     is_unsigned in  1   1 zero-extend, 0 sign-extend loads
//     load_data   out 32  extracted and extended load result
//     store_data  out 32  word to write back (merged for sub-word stores)
// -----------------------------------------------------------------------------
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  lsu_size_e   size,
  input  logic        is_unsigned,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    load_data  = rd_word;
    store_data = wdata;

    // Byte lane = addr[1:0]*8, half lane = addr[1]*16.
    byte_lane = rd_word[{addr_lo, 3'b000} +: 8];
    half_lane = rd_word[{addr_lo[1], 4'b0000} +: 16];

    unique case (size)
      SIZE_B: begin
        load_data  = is_unsigned ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
        store_data = old_word;
        store_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SIZE_H: begin
        load_data  = is_unsigned ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
        store_data = old_word;
        store_data[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data  = rd_word;
        store_data = wdata;
      end
    endcase
  end

endmodule : lsu_lane_align

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Initiator side of a word-addressed data-memory port (sync write, comb read).
//   Accepts byte/half/word loads and stores from the execute stage, extracts and
//   extends load lanes, and performs read-modify-write for sub-word stores.
//   Misaligned, reserved-size and out-of-range accesses complete with rsp_err.
//   Ports:
//     clk, rst        clock; asynchronous active-high reset
//     req_valid/ready request handshake (ready only in IDLE)
//     req_we          1 store, 0 load
//     req_size        00 byte, 01 half, 10 word, 11 reserved
//     req_unsigned    loads: 1 zero-extend, 0 sign-extend
//     req_addr        byte address
//     req_wdata       store data
//     rsp_valid       one-cycle completion pulse
//     rsp_rdata       extended load data (0 for stores/errors), held
//     rsp_err         error flag, held
//     mem_we/a/wd     memory write enable, word-aligned byte address, data
//     mem_rd          memory read data, combinational from mem_a
//   Latency accept->rsp_valid: error 1, load 2, word store 2, sub-word store 3.
// -----------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) * 64'd4;

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  lsu_size_e         size_q, size_d;
  logic              unsigned_q, unsigned_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       old_q, old_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              req_err;
  logic [31:0]       load_data;
  logic [31:0]       store_data;

  lsu_lane_align u_lane_align (
    .rd_word     (mem_rd),
    .old_word    (old_q),
    .wdata       (wdata_q),
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .load_data   (load_data),
    .store_data  (store_data)
  );

  // Evaluated on exactly the fields being latched at acceptance, so the
  // decision equals one made on the latched copy but costs no extra cycle.
  always_comb begin
    req_err = (req_size == SIZE_RSV)
            | ((req_size == SIZE_H) & req_addr[0])
            | ((req_size == SIZE_W) & (req_addr[1:0] != 2'b00))
            | (64'(req_addr) >= MEM_BYTES);
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    old_d       = old_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d       = req_we;
          size_d     = lsu_size_e'(req_size);
          unsigned_d = req_unsigned;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          if (req_err) begin
            state_d     = RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else if (req_we && (req_size == SIZE_W)) begin
            state_d = WR;
          end else begin
            // Loads and sub-word stores both need the current word first.
            state_d = RD;
          end
        end
      end
      RD: begin
        if (we_q) begin
          old_d   = mem_rd;
          state_d = WR;
        end else begin
          rsp_rdata_d = load_data;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end
      end
      WR: begin
        rsp_rdata_d = 32'h0;
        rsp_err_d   = 1'b0;
        state_d     = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge; the async reset clears all of them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= SIZE_B;
      unsigned_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      old_q       <= 32'h0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      unsigned_q  <= unsigned_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      old_q       <= old_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Memory-side controls decode straight from the state register, so an async
  // reset in WR drops mem_we immediately and no partial write can land.
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign mem_we    = (state_q == WR);
  assign mem_a     = ((state_q == RD) || (state_q == WR)) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wd    = (state_q == WR) ? store_data : 32'h0;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule : load_store_unit

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Self-checking bench for load_store_unit: directed cases plus randomized
//   requests compared with a behavioural access model and a shadow memory.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int MEM_WORDS = 1024;
  localparam int ADDR_W    = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'h0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_a;
  logic [31:0]       mem_wd;
  logic [31:0]       mem_rd;

  logic [31:0] dmem    [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_we       (mem_we),
    .mem_a        (mem_a),
    .mem_wd       (mem_wd),
    .mem_rd       (mem_rd)
  );

  // Data memory: combinational read, synchronous write.
  assign mem_rd = dmem[mem_a[11:2]];
  always @(posedge clk) begin
    if (mem_we) dmem[mem_a[11:2]] = mem_wd;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int unsigned byte_addr, input logic [31:0] val);
    dmem[byte_addr / 4]    = val;
    ref_mem[byte_addr / 4] = val;
  endtask

  // Behavioural model of one access: result, error, latency, write pulses.
  task automatic ref_access(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wd,
                            output logic [31:0] rdata, output logic err,
                            output int lat, output int wes);
    int unsigned a   = addr;
    int unsigned sh  = 8 * (a % 4);
    int unsigned idx = a / 4;
    logic [31:0] word, v, mask;
    err = (size == 2'd3) || (size == 2'd1 && a % 2 != 0) ||
          (size == 2'd2 && a % 4 != 0) || (a >= MEM_WORDS * 4);
    rdata = 32'h0;
    wes   = 0;
    if (err) begin
      lat = 1;
      return;
    end
    word = ref_mem[idx];
    if (!we) begin
      lat = 2;
      case (size)
        2'd0: begin
          v = (word >> sh) & 32'hFF;
          if (!uns && v >= 128) v = v - 32'd256;
        end
        2'd1: begin
          v = (word >> sh) & 32'hFFFF;
          if (!uns && v >= 32768) v = v - 32'd65536;
        end
        default: v = word;
      endcase
      rdata = v;
    end else begin
      lat  = (size == 2'd2) ? 2 : 3;
      wes  = 1;
      mask = (size == 2'd0) ? (32'hFF << sh) : (size == 2'd1) ? (32'hFFFF << sh) : 32'hFFFF_FFFF;
      ref_mem[idx] = (word & ~mask) | ((wd << sh) & mask);
    end
  endtask

  // Issue one request, optionally keep junk on the request bus while busy,
  // and compare latency, write pulses, response data and error.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input bit junk, input string tag, output logic [31:0] got);
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat, exp_wes;
    int          lat = 0;
    int          wes = 0;
    ref_access(we, size, uns, addr, wd, exp_rdata, exp_err, exp_lat, exp_wes);
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    if (junk) begin
      req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
    end else begin
      req_valid = 1'b0;
    end
    for (int c = 1; c <= 8; c++) begin
      if (mem_we) wes++;
      if (rsp_valid) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    got = rsp_rdata;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " we_pulses"}, 32'(wes), 32'(exp_wes));
    check({tag, " rdata"}, rsp_rdata, exp_rdata);
    check({tag, " err"}, 32'(rsp_err), 32'(exp_err));
    @(posedge clk); #1;
    check({tag, " valid_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, " rdata_held"}, rsp_rdata, exp_rdata);
  endtask

  initial begin
    logic [31:0] got;
    int          bad;
    int unsigned r, a;
    logic [1:0]  sz;

    for (int i = 0; i < MEM_WORDS; i++) begin
      logic [31:0] v;
      v = (i < 64) ? $urandom : 32'(i) * 32'h0101_0101;
      dmem[i]    = v;
      ref_mem[i] = v;
    end

    // Reset state
    #2 rst = 1'b1;
    #1;
    check("rst ready", 32'(req_ready), 32'd1);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_rdata", rsp_rdata, 32'h0);
    check("rst rsp_err", 32'(rsp_err), 32'd0);
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst mem_a", mem_a, 32'h0);
    check("rst mem_wd", mem_wd, 32'h0);
    @(posedge clk); #2 rst = 1'b0;
    #1;

    // Word store then word load
    do_req(1'b1, 2'd2, 1'b0, 32'h70, 32'hDEAD_BEEF, 1'b0, "wst70", got);
    check("wst70 mem", dmem[32'h70 / 4], 32'hDEAD_BEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h70, 32'h0, 1'b0, "wld70", got);
    check("wld70 value", got, 32'hDEAD_BEEF);

    // Lane extraction and extension
    preload(32'h40, 32'h80F1_7F02);
    do_req(1'b0, 2'd0, 1'b0, 32'h43, 32'h0, 1'b0, "lb43", got);
    check("lb43 value", got, 32'hFFFF_FF80);
    do_req(1'b0, 2'd0, 1'b1, 32'h42, 32'h0, 1'b0, "lbu42", got);
    check("lbu42 value", got, 32'h0000_00F1);
    do_req(1'b0, 2'd1, 1'b0, 32'h42, 32'h0, 1'b1, "lh42", got);
    check("lh42 value", got, 32'hFFFF_80F1);
    do_req(1'b0, 2'd1, 1'b0, 32'h40, 32'h0, 1'b0, "lh40", got);
    check("lh40 value", got, 32'h0000_7F02);

    // Sub-word store read-modify-write
    preload(32'h40, 32'h1122_3344);
    do_req(1'b1, 2'd0, 1'b0, 32'h41, 32'h5555_55AA, 1'b1, "sb41", got);
    check("sb41 mem", dmem[32'h40 / 4], 32'h1122_AA44);
    check("sb41 rdata", got, 32'h0);

    // Error cases
    do_req(1'b0, 2'd2, 1'b0, 32'h42, 32'h0, 1'b0, "err_wmis", got);
    do_req(1'b0, 2'd1, 1'b0, 32'h41, 32'h0, 1'b0, "err_hmis", got);
    do_req(1'b0, 2'd3, 1'b0, 32'h44, 32'h0, 1'b0, "err_rsv", got);
    do_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 1'b0, "err_oor", got);
    do_req(1'b1, 2'd2, 1'b0, 32'h1000, 32'h1234_5678, 1'b0, "err_oor_st", got);
    do_req(1'b1, 2'd2, 1'b0, 32'hFFC, 32'hCAFE_F00D, 1'b0, "wst_last", got);
    check("wst_last mem", dmem[MEM_WORDS - 1], 32'hCAFE_F00D);

    // Reset during the write cycle of a sub-word store
    preload(32'h60, 32'h1122_3344);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h61; req_wdata = 32'h0000_00AA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("midrst we_before", 32'(mem_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst we_async", 32'(mem_we), 32'd0);
    check("midrst ready", 32'(req_ready), 32'd1);
    check("midrst mem_a", mem_a, 32'h0);
    @(posedge clk); #2 rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) bad++;
    end
    check("midrst no_rsp", 32'(bad), 32'd0);
    check("midrst mem", dmem[32'h60 / 4], 32'h1122_3344);

    // Randomized requests
    for (int n = 0; n < 300; n++) begin
      r  = $urandom_range(0, 19);
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'h1000 - $urandom_range(0, 4) + $urandom_range(0, 3);
      else             a = $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a = a & ~32'd1;
        if (sz == 2'd2) a = a & ~32'd3;
      end
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, 1'($urandom), "rand", got);
    end

    // Whole-memory comparison against the shadow model
    bad = 0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      if (dmem[i] !== ref_mem[i]) bad++;
    end
    check("final mem_words_differing", 32'(bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_load_store_unit
